// File: rtl/countdown_core_pkg.sv
// Shared definitions for the egg-timer countdown engine: FSM state encoding
// and default sizing constants.
package countdown_defs;

   typedef enum logic [1:0] {
      CD_IDLE  = 2'd0,
      CD_RUN   = 2'd1,
      CD_PAUSE = 2'd2,
      CD_DONE  = 2'd3
   } cd_state_t;

   localparam int CD_SIZE    = 4;
   localparam int CD_CLK_DIV = 50000000;

endpackage

// File: rtl/countdown_core_if.sv
// Control/status bundle between the timer front panel and countdown_core.
interface countdown_core_if #(parameter int SIZE = 4);

   logic            start;
   logic            pause;
   logic [SIZE-1:0] load_val;
   logic [SIZE-1:0] count;
   logic            alarm;
   logic            running;

   modport master (output start, output pause, output load_val,
                   input count, input alarm, input running);

   modport slave  (input start, input pause, input load_val,
                   output count, output alarm, output running);

endinterface

// File: rtl/countdown_core_sec_prescaler.sv
// Divides the system clock down to a one-cycle second tick. The tick is
// combinational so the count register can act on the same edge the divider wraps.
module sec_prescaler
   import countdown_defs::*;
#(
   parameter int CLK_DIV = CD_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int DIV_W = $clog2(CLK_DIV);

   logic [DIV_W-1:0] div_cnt;

   assign tick = en && !clr && (div_cnt == DIV_W'(CLK_DIV - 1));

   // clr has priority so a restart always begins a full second from zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
      end else if (clr) begin
         div_cnt <= '0;
      end else if (en) begin
         if (tick) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/countdown_core.sv
// Countdown engine: loads a duration, decrements once per second tick and
// pulses alarm at zero. Define COUNTDOWN_AUTORELOAD_EN to restart automatically.
module countdown_core
   import countdown_defs::*;
#(
   parameter int SIZE    = CD_SIZE,
   parameter int CLK_DIV = CD_CLK_DIV
) (
   input logic              clk,
   input logic              rst,
   countdown_core_if.slave  cd
);

   cd_state_t       state, state_next;
   logic [SIZE-1:0] count_q, count_next;
   logic            alarm_q, alarm_next;
   logic            running_q;
   logic            tick;

   sec_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (state == CD_RUN),
      .clr  (cd.start),
      .tick (tick)
   );

`ifdef COUNTDOWN_AUTORELOAD_EN
   logic [SIZE-1:0] reload_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reload_reg <= '0;
      end else if (cd.start) begin
         reload_reg <= cd.load_val;
      end
   end
`endif

   // State, count and alarm are all registered together so they change on one edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= CD_IDLE;
         count_q   <= '0;
         alarm_q   <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state     <= state_next;
         count_q   <= count_next;
         alarm_q   <= alarm_next;
         running_q <= (state_next == CD_RUN);
      end
   end

   // A tick and a pause on the same edge both take effect, unless the tick finishes the count
   always_comb begin
      state_next = state;
      count_next = count_q;
      alarm_next = 1'b0;
      if (cd.start) begin
         count_next = cd.load_val;
         if (cd.load_val == '0) begin
            state_next = CD_DONE;
            alarm_next = 1'b1;
         end else begin
            state_next = CD_RUN;
         end
      end else begin
         case (state)
            CD_RUN: begin
               if (tick) begin
                  if (count_q > SIZE'(1)) begin
                     count_next = count_q - SIZE'(1);
                  end else begin
                     alarm_next = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                     count_next = reload_reg;
`else
                     count_next = '0;
                     state_next = CD_DONE;
`endif
                  end
               end
               if (cd.pause && state_next == CD_RUN) begin
                  state_next = CD_PAUSE;
               end
            end
            CD_PAUSE: begin
               if (cd.pause) begin
                  state_next = CD_RUN;
               end
            end
            default: begin
               state_next = state;
            end
         endcase
      end
   end

   assign cd.count   = count_q;
   assign cd.alarm   = alarm_q;
   assign cd.running = running_q;

endmodule

// File: tb/tb_countdown_core.sv
// Scoreboard bench for countdown_core with SIZE=4, CLK_DIV=4.
module tb_countdown_core;
   import countdown_defs::*;

   localparam int SIZE = 4;
   localparam int DIV  = 4;

   typedef struct {
      int count;
      int alarm;
      int running;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t sb_q[$];

   countdown_core_if #(.SIZE(SIZE)) cdIf ();

   countdown_core #(.SIZE(SIZE), .CLK_DIV(DIV)) dut (
      .clk (clk),
      .rst (rst),
      .cd  (cdIf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   task automatic compareNext(input string tag);
      exp_t e;
      e = sb_q.pop_front();
      checkOutput({tag, " count"}, 32'(cdIf.count), 32'(e.count));
      checkOutput({tag, " alarm"}, 32'(cdIf.alarm), 32'(e.alarm));
      checkOutput({tag, " running"}, 32'(cdIf.running), 32'(e.running));
   endtask

   // Drive one cycle of inputs, queue the outputs expected after the edge, then compare
   task automatic applyStimulus(input string tag, input logic st, input logic pa,
                                input logic [SIZE-1:0] lv, input int ec, input int ea, input int er);
      exp_t e;
      @(negedge clk);
      cdIf.start    = st;
      cdIf.pause    = pa;
      cdIf.load_val = lv;
      e.count   = ec;
      e.alarm   = ea;
      e.running = er;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      compareNext(tag);
   endtask

   initial begin
      int c, a, r, eff;
      exp_t e;
      checks = 0;
      errors = 0;
      rst           = 1'b0;
      cdIf.start    = 1'b0;
      cdIf.pause    = 1'b0;
      cdIf.load_val = '0;

      for (int k = 0; k < 2; k++) begin
         applyStimulus($sformatf("in_reset k=%0d", k), 1'b0, 1'b0, 4'd0, 0, 0, 0);
      end
      @(negedge clk);
      rst = 1'b1;

      for (int k = 0; k < 20; k++) begin
         applyStimulus($sformatf("idle k=%0d", k), 1'b0, (k % 7) == 3, 4'd0, 0, 0, 0);
      end

`ifndef COUNTDOWN_AUTORELOAD_EN
      for (int k = 0; k < 16; k++) begin
         if (k < 12) begin c = 3 - k / DIV; a = 0; r = 1; end
         else if (k == 12) begin c = 0; a = 1; r = 0; end
         else begin c = 0; a = 0; r = 0; end
         applyStimulus($sformatf("run3 k=%0d", k), k == 0, 1'b0, 4'd3, c, a, r);
      end

      for (int k = 0; k < 21; k++) begin
         if (k < 5) begin c = 3 - k / DIV; a = 0; r = 1; end
         else if (k <= 10) begin c = 2; a = 0; r = 0; end
         else begin
            eff = k - 6;
            if (eff < 12) begin c = 3 - eff / DIV; a = 0; r = 1; end
            else if (eff == 12) begin c = 0; a = 1; r = 0; end
            else begin c = 0; a = 0; r = 0; end
         end
         applyStimulus($sformatf("pause k=%0d", k), k == 0, (k == 5) || (k == 11), 4'd3, c, a, r);
      end
`endif

      for (int k = 0; k < 6; k++) begin
         applyStimulus($sformatf("zero k=%0d", k), k == 0, 1'b0, 4'd0, 0, (k == 0) ? 1 : 0, 0);
      end

`ifndef COUNTDOWN_AUTORELOAD_EN
      for (int k = 0; k < 11; k++) begin
         if (k < 8) begin c = 2 - k / DIV; a = 0; r = 1; end
         else if (k == 8) begin c = 0; a = 1; r = 0; end
         else begin c = 0; a = 0; r = 0; end
         applyStimulus($sformatf("startpause k=%0d", k), k == 0, k == 0, 4'd2, c, a, r);
      end

      for (int k = 0; k < 12; k++) begin
         if (k < 6) begin c = 5 - k / DIV; a = 0; r = 1; end
         else if (k < 10) begin c = 1; a = 0; r = 1; end
         else if (k == 10) begin c = 0; a = 1; r = 0; end
         else begin c = 0; a = 0; r = 0; end
         applyStimulus($sformatf("restart k=%0d", k), (k == 0) || (k == 6), 1'b0,
                       (k < 6) ? 4'd5 : 4'd1, c, a, r);
      end

      for (int k = 0; k < 9; k++) begin
         applyStimulus($sformatf("max k=%0d", k), k == 0, 1'b0, 4'd15, 15 - k / DIV, 0, 1);
      end
      #1;
      rst = 1'b0;
      #1;
      e.count = 0; e.alarm = 0; e.running = 0;
      sb_q.push_back(e);
      compareNext("async_reset");
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 12; k++) begin
         applyStimulus($sformatf("post_reset k=%0d", k), 1'b0, 1'b0, 4'd15, 0, 0, 0);
      end
`else
      for (int k = 0; k < 27; k++) begin
         c = 2 - (k % 8) / DIV;
         a = (k > 0 && (k % 8) == 0) ? 1 : 0;
         applyStimulus($sformatf("reload k=%0d", k), k == 0, 1'b0, 4'd2, c, a, 1);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
